// File: rtl/lu_pkg.sv
// Shared types and constants for the LU row buffer: complex element type and FSM states.
// Optional read/write bypass in lu_row_mem is enabled with LU_ROW_BUF_BYPASS_EN.
package lu_pkg;

   localparam int CPLX_W = 128;

   // {imag, real}, each an IEEE-754 double
   typedef logic [CPLX_W-1:0] cplx_t;

   localparam cplx_t CPLX_ONE = {64'b0, 64'h3ff0000000000000};

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_BUSY,
      RUN
   } lu_buf_state_t;

endpackage

// File: rtl/lu_row_buffer_if.sv
// Host-load, LU read/write-back and LU control signals of the row buffer.
// No configuration macros; LU_ROW_BUF_BYPASS_EN only affects lu_row_mem.
interface lu_row_buffer_if
   import lu_pkg::*;
#(
   parameter int SIZE = 16
) ();

   localparam int AW = $clog2(SIZE);
   localparam int RW = SIZE * CPLX_W;

   logic [RW-1:0] in_row_i;
   logic          in_row_valid_i;
   logic          in_row_ready_o;
   logic          load_start_i;

   logic [AW-1:0] rd_addr_i;
   logic          rd_addr_valid_i;
   logic [RW-1:0] row_o;
   logic [AW-1:0] row_addr_o;
   logic          row_valid_o;

   logic [RW-1:0] wr_row_i;
   logic [AW-1:0] wr_addr_i;
   logic          wr_valid_i;
   logic          wr_ready_o;

   logic          lu_start_o;
   logic          lu_busy_i;
   logic          busy_o;
   logic          done_o;

   modport slave (
      input  in_row_i, in_row_valid_i, load_start_i,
      input  rd_addr_i, rd_addr_valid_i,
      input  wr_row_i, wr_addr_i, wr_valid_i,
      input  lu_busy_i,
      output in_row_ready_o, row_o, row_addr_o, row_valid_o,
      output wr_ready_o, lu_start_o, busy_o, done_o
   );

   modport master (
      output in_row_i, in_row_valid_i, load_start_i,
      output rd_addr_i, rd_addr_valid_i,
      output wr_row_i, wr_addr_i, wr_valid_i,
      output lu_busy_i,
      input  in_row_ready_o, row_o, row_addr_o, row_valid_o,
      input  wr_ready_o, lu_start_o, busy_o, done_o
   );

endinterface

// File: rtl/lu_row_mem.sv
// SIZE-row register array, one write port, one registered read port.
// LU_ROW_BUF_BYPASS_EN defined: same-address read/write returns the write data (write-first).
module lu_row_mem
   import lu_pkg::*;
#(
   parameter int SIZE = 16,
   localparam int AW = $clog2(SIZE),
   localparam int RW = SIZE * CPLX_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [RW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [RW-1:0] rdata,
   output logic [AW-1:0] raddr_q,
   output logic          rvalid
);

   logic [RW-1:0] mem [SIZE];

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata   <= '0;
         raddr_q <= '0;
         rvalid  <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) begin
            raddr_q <= raddr;
`ifdef LU_ROW_BUF_BYPASS_EN
            if (we && (waddr == raddr)) rdata <= wdata;
            else                        rdata <= mem[raddr];
`else
            rdata <= mem[raddr];
`endif
         end
      end
   end

endmodule

// File: rtl/lu_row_buffer.sv
// Matrix row store in front of the LU engine: host load, LU start, row serve/write-back.
// LU_ROW_BUF_BYPASS_EN selects write-first collision behaviour inside lu_row_mem.
//
// state     | meaning
// IDLE      | waiting for load_start_i; host may read back the matrix
// LOAD      | accepting SIZE host rows in order
// START     | one-cycle lu_start_o pulse
// WAIT_BUSY | waiting for LU to raise busy; write-backs accepted
// RUN       | LU working; done_o pulses when busy drops
module lu_row_buffer
   import lu_pkg::*;
#(
   parameter int SIZE = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   lu_row_buffer_if.slave bus
);

   localparam int AW = $clog2(SIZE);
   localparam int RW = SIZE * CPLX_W;

   lu_buf_state_t state, state_nxt;
   logic [AW-1:0] load_cnt;
   logic          load_acc;
   logic          wb_acc;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [RW-1:0] mem_wdata;

   assign load_acc = (state == LOAD) && bus.in_row_valid_i;
   assign wb_acc   = ((state == WAIT_BUSY) || (state == RUN)) && bus.wr_valid_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= IDLE;
         load_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (load_acc) load_cnt <= load_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt          = state;
      bus.in_row_ready_o = 1'b0;
      bus.wr_ready_o     = 1'b0;
      bus.lu_start_o     = 1'b0;
      bus.busy_o         = (state != IDLE);
      bus.done_o         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load_start_i) state_nxt = LOAD;
         end
         LOAD: begin
            bus.in_row_ready_o = 1'b1;
            if (load_acc && (load_cnt == AW'(SIZE - 1))) state_nxt = START;
         end
         START: begin
            bus.lu_start_o = 1'b1;
            state_nxt      = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            bus.wr_ready_o = 1'b1;
            if (bus.lu_busy_i) state_nxt = RUN;
         end
         RUN: begin
            bus.wr_ready_o = 1'b1;
            if (!bus.lu_busy_i) begin
               bus.done_o = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Load and write-back are never accepted in the same state, so a simple mux suffices.
   assign mem_we    = load_acc | wb_acc;
   assign mem_waddr = load_acc ? load_cnt     : bus.wr_addr_i;
   assign mem_wdata = load_acc ? bus.in_row_i : bus.wr_row_i;

   lu_row_mem #(
      .SIZE (SIZE)
   ) u_mem (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .we      (mem_we),
      .waddr   (mem_waddr),
      .wdata   (mem_wdata),
      .re      (bus.rd_addr_valid_i),
      .raddr   (bus.rd_addr_i),
      .rdata   (bus.row_o),
      .raddr_q (bus.row_addr_o),
      .rvalid  (bus.row_valid_o)
   );

endmodule

// File: tb/tb_lu_row_buffer.sv
// Directed bench for lu_row_buffer with a read scoreboard and a reference row model.
// Collision expectations follow LU_ROW_BUF_BYPASS_EN.
module tb_lu_row_buffer;
   import lu_pkg::*;

   localparam int SIZE = 16;
   localparam int AW   = $clog2(SIZE);
   localparam int RW   = SIZE * CPLX_W;

   typedef logic [RW-1:0] row_t;
   typedef struct {
      logic [AW-1:0] addr;
      row_t          row;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   lu_row_buffer_if #(.SIZE(SIZE)) bus ();

   lu_row_buffer #(.SIZE(SIZE)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   row_t model [SIZE];
   exp_t sb [$];
   int   passes = 0;
   int   fails  = 0;
   int   total  = 0;

   function automatic row_t mk_ramp(input int base);
      row_t  r;
      cplx_t e;
      for (int j = 0; j < SIZE; j++) begin
         e = {64'b0, $realtobits(real'(base + j))};
         r[j*CPLX_W +: CPLX_W] = e;
      end
      return r;
   endfunction

   function automatic row_t mk_const(input real v);
      row_t  r;
      cplx_t e;
      e = {64'b0, $realtobits(v)};
      for (int j = 0; j < SIZE; j++) r[j*CPLX_W +: CPLX_W] = e;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_row(input string tag, input row_t obs, input row_t exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed[255:0]=%0h expected[255:0]=%0h", tag, obs[255:0], exp[255:0]);
      end
   endtask

   task automatic rd_req(input logic [AW-1:0] a, input row_t exp_row);
      bus.rd_addr_i       = a;
      bus.rd_addr_valid_i = 1'b1;
      sb.push_back('{addr: a, row: exp_row});
   endtask

   // Advance one clock; any read issued for this edge is scored one cycle later.
   task automatic tick();
      exp_t e;
      logic issued;
      issued = bus.rd_addr_valid_i;
      @(posedge clk);
      #1;
      bus.rd_addr_valid_i = 1'b0;
      bus.wr_valid_i      = 1'b0;
      bus.load_start_i    = 1'b0;
      bus.in_row_valid_i  = 1'b0;
      if (issued) begin
         chk("rd_valid", 64'(bus.row_valid_o), 64'd1);
         if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rd_addr", 64'(bus.row_addr_o), 64'(e.addr));
            chk_row("rd_row", bus.row_o, e.row);
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_row"},   64'(bus.row_o != '0), 64'd0);
      chk({tag, "_raddr"}, 64'(bus.row_addr_o), 64'd0);
      chk({tag, "_rvld"},  64'(bus.row_valid_o), 64'd0);
      chk({tag, "_inrdy"}, 64'(bus.in_row_ready_o), 64'd0);
      chk({tag, "_wrrdy"}, 64'(bus.wr_ready_o), 64'd0);
      chk({tag, "_start"}, 64'(bus.lu_start_o), 64'd0);
      chk({tag, "_busy"},  64'(bus.busy_o), 64'd0);
      chk({tag, "_done"},  64'(bus.done_o), 64'd0);
   endtask

   // Start a load and feed SIZE rows with an idle cycle before each one.
   task automatic load_matrix(input int base);
      bus.load_start_i = 1'b1;
      tick();
      chk("load_inrdy", 64'(bus.in_row_ready_o), 64'd1);
      for (int r = 0; r < SIZE; r++) begin
         bus.in_row_i = ~mk_ramp(base);
         tick();
         bus.in_row_i       = mk_ramp(base + r * SIZE);
         bus.in_row_valid_i = 1'b1;
         model[r]           = mk_ramp(base + r * SIZE);
         tick();
      end
   endtask

   initial begin
      row_t x;
      row_t y;
      rst_n               = 1'b0;
      bus.in_row_i        = '0;
      bus.in_row_valid_i  = 1'b0;
      bus.load_start_i    = 1'b0;
      bus.rd_addr_i       = '0;
      bus.rd_addr_valid_i = 1'b0;
      bus.wr_row_i        = '0;
      bus.wr_addr_i       = '0;
      bus.wr_valid_i      = 1'b0;
      bus.lu_busy_i       = 1'b0;
      tick();
      tick();
      chk_all_zero("rst");
      rst_n = 1'b1;

      // Host valid while IDLE must not advance the load pointer
      bus.in_row_i       = mk_const(-1.0);
      bus.in_row_valid_i = 1'b1;
      tick();
      chk("idle_busy", 64'(bus.busy_o), 64'd0);

      load_matrix(0);
      chk("start_pulse", 64'(bus.lu_start_o), 64'd1);
      chk("start_busy",  64'(bus.busy_o), 64'd1);
      chk("start_inrdy", 64'(bus.in_row_ready_o), 64'd0);
      tick();
      chk("start_once",  64'(bus.lu_start_o), 64'd0);
      chk("wait_wrrdy",  64'(bus.wr_ready_o), 64'd1);

      rd_req(5, model[5]);
      tick();
      chk("r5_e3_real", 64'(bus.row_o[3*CPLX_W +: 64]), $realtobits(83.0));
      tick();
      chk("rd_idle_vld", 64'(bus.row_valid_o), 64'd0);
      chk("rd_hold_addr", 64'(bus.row_addr_o), 64'd5);
      chk_row("rd_hold_row", bus.row_o, model[5]);

      bus.lu_busy_i = 1'b1;
      tick();
      chk("run_busy", 64'(bus.busy_o), 64'd1);
      chk("run_done", 64'(bus.done_o), 64'd0);

      bus.load_start_i = 1'b1;
      rd_req(0, model[0]);
      tick();
      chk("run_ld_ign", 64'(bus.in_row_ready_o), 64'd0);
      rd_req(15, model[15]);
      tick();

      bus.wr_addr_i  = 7;
      bus.wr_row_i   = mk_const(2.0);
      bus.wr_valid_i = 1'b1;
      model[7]       = mk_const(2.0);
      tick();
      rd_req(7, model[7]);
      tick();

      // Same-cycle read and write of row 3
      x = mk_const(3.5);
      y = model[3];
      bus.wr_addr_i  = 3;
      bus.wr_row_i   = x;
      bus.wr_valid_i = 1'b1;
`ifdef LU_ROW_BUF_BYPASS_EN
      rd_req(3, x);
`else
      rd_req(3, y);
`endif
      model[3] = x;
      tick();
      rd_req(3, model[3]);
      tick();

      bus.lu_busy_i = 1'b0;
      #1;
      chk("done_pulse", 64'(bus.done_o), 64'd1);
      tick();
      chk("done_once",  64'(bus.done_o), 64'd0);
      chk("end_busy",   64'(bus.busy_o), 64'd0);
      chk("end_wrrdy",  64'(bus.wr_ready_o), 64'd0);

      // Write-back in IDLE is dropped
      bus.wr_addr_i  = 7;
      bus.wr_row_i   = {SIZE{CPLX_ONE}};
      bus.wr_valid_i = 1'b1;
      tick();
      rd_req(7, model[7]);
      tick();

      // Abandon a run with reset
      load_matrix(1000);
      tick();
      bus.lu_busy_i = 1'b1;
      tick();
      rd_req(2, model[2]);
      tick();
      rst_n = 1'b0;
      tick();
      chk_all_zero("rst_run");
      rst_n         = 1'b1;
      bus.lu_busy_i = 1'b0;
      tick();
      chk("post_rst_done", 64'(bus.done_o), 64'd0);
      chk("post_rst_busy", 64'(bus.busy_o), 64'd0);

      load_matrix(2000);
      chk("reload_start", 64'(bus.lu_start_o), 64'd1);
      rd_req(9, model[9]);
      tick();
      rd_req(0, model[0]);
      tick();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
